// File: rtl/rs_gen.sv
// ---------------------------------------------------------------------------
// rs_gen : parametrised reservation station
//
// Holds decoded ALU/branch ops until both operands are resolved. It snoops
// NCDB result-broadcast channels and dispatches one op per cycle, oldest
// ready first, into a registered valid/ready port that feeds the ALU.
//
// Ports
//   clk_in, rst_in      clock, synchronous active-high reset
//   rdy_in              global enable; low freezes all state
//   clear               misprediction flush (beats issue and dispatch)
//   rs_full, rs_count   occupancy, combinational from the busy bits
//   dec_ready           issue strobe from the decoder
//   op_type             op code: [4] branch, [3] inst[30], [2:0] funct3
//   val_j/val_k         operand values when there is no dependency
//   has_dep_j/has_dep_k operand waits on a ROB tag
//   dep_j/dep_k         producer ROB tags
//   rob_id              destination ROB tag
//   tja/fja             taken / not-taken branch targets
//   cdb_valid           per-channel broadcast valid
//   cdb_rob_id          channel c tag at [c*ROB_WIDTH +: ROB_WIDTH]
//   cdb_value           channel c value at [c*XLEN +: XLEN]
//   out_valid/out_ready dispatch handshake with the ALU
//   out_op, out_lhs, out_rhs, out_rob_id, out_tja, out_fja  dispatched op
// ---------------------------------------------------------------------------
module rs_gen #(
    parameter int RS_SIZE   = 8,
    parameter int RS_WIDTH  = 3,
    parameter int ROB_WIDTH = 4,
    parameter int NCDB      = 2,
    parameter int XLEN      = 32
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      clear,
    output logic                      rs_full,
    output logic [RS_WIDTH:0]         rs_count,
    input  logic                      dec_ready,
    input  logic [4:0]                op_type,
    input  logic [XLEN-1:0]           val_j,
    input  logic [XLEN-1:0]           val_k,
    input  logic                      has_dep_j,
    input  logic                      has_dep_k,
    input  logic [ROB_WIDTH-1:0]      dep_j,
    input  logic [ROB_WIDTH-1:0]      dep_k,
    input  logic [ROB_WIDTH-1:0]      rob_id,
    input  logic [XLEN-1:0]           tja,
    input  logic [XLEN-1:0]           fja,
    input  logic [NCDB-1:0]           cdb_valid,
    input  logic [NCDB*ROB_WIDTH-1:0] cdb_rob_id,
    input  logic [NCDB*XLEN-1:0]      cdb_value,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4:0]                out_op,
    output logic [XLEN-1:0]           out_lhs,
    output logic [XLEN-1:0]           out_rhs,
    output logic [ROB_WIDTH-1:0]      out_rob_id,
    output logic [XLEN-1:0]           out_tja,
    output logic [XLEN-1:0]           out_fja
);

    // Entry storage
    logic [RS_SIZE-1:0]   r_busy;
    logic [RS_SIZE-1:0]   r_dj;
    logic [RS_SIZE-1:0]   r_dk;
    logic [4:0]           r_op   [RS_SIZE];
    logic [XLEN-1:0]      r_vj   [RS_SIZE];
    logic [XLEN-1:0]      r_vk   [RS_SIZE];
    logic [ROB_WIDTH-1:0] r_qj   [RS_SIZE];
    logic [ROB_WIDTH-1:0] r_qk   [RS_SIZE];
    logic [ROB_WIDTH-1:0] r_dest [RS_SIZE];
    logic [XLEN-1:0]      r_tja  [RS_SIZE];
    logic [XLEN-1:0]      r_fja  [RS_SIZE];
    logic [RS_WIDTH-1:0]  r_age  [RS_SIZE];

    // Combinational helpers
    logic [RS_SIZE-1:0]   w_ready;
    logic                 w_issue;
    logic [RS_WIDTH-1:0]  w_issueIdx;
    logic                 w_issueFound;
    logic                 w_load;
    logic                 w_anyReady;
    logic                 w_dispatch;
    logic [RS_WIDTH-1:0]  w_dispIdx;
    logic [RS_WIDTH-1:0]  w_dispAge;
    logic [XLEN-1:0]      w_newVj;
    logic [XLEN-1:0]      w_newVk;
    logic                 w_newDj;
    logic                 w_newDk;
    logic [XLEN-1:0]      w_nextVj [RS_SIZE];
    logic [XLEN-1:0]      w_nextVk [RS_SIZE];
    logic [RS_SIZE-1:0]   w_nextDj;
    logic [RS_SIZE-1:0]   w_nextDk;
    logic [RS_WIDTH-1:0]  w_ageNext [RS_SIZE];
    logic [RS_WIDTH:0]    w_count;

    // Occupancy is derived purely from the current busy bits, so a dispatch
    // happening this cycle does not make room until the next cycle.
    always_comb begin
        w_count = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_count = w_count + (RS_WIDTH+1)'(r_busy[i]);
        end
    end

    assign rs_count = w_count;
    assign rs_full  = &r_busy;

    // An issue request while full is dropped; otherwise the op goes into
    // the lowest-numbered idle entry.
    always_comb begin
        w_issueIdx   = '0;
        w_issueFound = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!r_busy[i] && !w_issueFound) begin
                w_issueIdx   = RS_WIDTH'(i);
                w_issueFound = 1'b1;
            end
        end
    end

    assign w_issue = dec_ready && !rs_full;

    // Operand capture at issue time: a broadcast of the awaited tag in the
    // same cycle is bypassed straight into the new entry. The channel loop
    // runs downwards so the lowest matching channel is the one that sticks.
    always_comb begin
        w_newVj = val_j;
        w_newDj = has_dep_j;
        w_newVk = val_k;
        w_newDk = has_dep_k;
        for (int c = NCDB-1; c >= 0; c--) begin
            if (has_dep_j && cdb_valid[c] && cdb_rob_id[c*ROB_WIDTH +: ROB_WIDTH] == dep_j) begin
                w_newVj = cdb_value[c*XLEN +: XLEN];
                w_newDj = 1'b0;
            end
            if (has_dep_k && cdb_valid[c] && cdb_rob_id[c*ROB_WIDTH +: ROB_WIDTH] == dep_k) begin
                w_newVk = cdb_value[c*XLEN +: XLEN];
                w_newDk = 1'b0;
            end
        end
    end

    // Wakeup of waiting entries from the broadcast channels, again letting
    // the lowest matching channel win.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_nextVj[i] = r_vj[i];
            w_nextDj[i] = r_dj[i];
            w_nextVk[i] = r_vk[i];
            w_nextDk[i] = r_dk[i];
            for (int c = NCDB-1; c >= 0; c--) begin
                if (r_dj[i] && cdb_valid[c] && cdb_rob_id[c*ROB_WIDTH +: ROB_WIDTH] == r_qj[i]) begin
                    w_nextVj[i] = cdb_value[c*XLEN +: XLEN];
                    w_nextDj[i] = 1'b0;
                end
                if (r_dk[i] && cdb_valid[c] && cdb_rob_id[c*ROB_WIDTH +: ROB_WIDTH] == r_qk[i]) begin
                    w_nextVk[i] = cdb_value[c*XLEN +: XLEN];
                    w_nextDk[i] = 1'b0;
                end
            end
        end
    end

    // Oldest-ready selection. Ages are unique among busy entries, so a
    // strict greater-than comparison is enough to find the single oldest.
    // Selection only looks at registered state, so an entry written or
    // woken this cycle cannot be picked until the next one.
    always_comb begin
        w_anyReady = 1'b0;
        w_dispIdx  = '0;
        w_dispAge  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_ready[i] = r_busy[i] && !r_dj[i] && !r_dk[i];
            if (w_ready[i] && (!w_anyReady || r_age[i] > w_dispAge)) begin
                w_anyReady = 1'b1;
                w_dispIdx  = RS_WIDTH'(i);
                w_dispAge  = r_age[i];
            end
        end
    end

    assign w_load     = !out_valid || out_ready;
    assign w_dispatch = w_load && w_anyReady;

    // Age bookkeeping keeps ages equal to rank among busy entries: a new
    // issue pushes everyone one step older, and removing an entry pulls
    // the entries older than it one step younger to close the gap.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_ageNext[i] = r_age[i] + RS_WIDTH'(w_issue)
                         - RS_WIDTH'(w_dispatch && (r_age[i] > w_dispAge));
        end
    end

    // Main state register. Reset and flush both empty the station and the
    // dispatch register; rdy_in low freezes everything including wakeups.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_busy     <= '0;
            r_dj       <= '0;
            r_dk       <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_age[i] <= '0;
            end
            out_valid  <= 1'b0;
            out_op     <= '0;
            out_lhs    <= '0;
            out_rhs    <= '0;
            out_rob_id <= '0;
            out_tja    <= '0;
            out_fja    <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                r_busy     <= '0;
                r_dj       <= '0;
                r_dk       <= '0;
                for (int i = 0; i < RS_SIZE; i++) begin
                    r_age[i] <= '0;
                end
                out_valid  <= 1'b0;
                out_op     <= '0;
                out_lhs    <= '0;
                out_rhs    <= '0;
                out_rob_id <= '0;
                out_tja    <= '0;
                out_fja    <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (r_busy[i]) begin
                        r_vj[i]  <= w_nextVj[i];
                        r_vk[i]  <= w_nextVk[i];
                        r_dj[i]  <= w_nextDj[i];
                        r_dk[i]  <= w_nextDk[i];
                        r_age[i] <= w_ageNext[i];
                    end
                end

                if (w_dispatch) begin
                    r_busy[w_dispIdx] <= 1'b0;
                    out_valid         <= 1'b1;
                    out_op            <= r_op[w_dispIdx];
                    out_lhs           <= r_vj[w_dispIdx];
                    out_rhs           <= r_vk[w_dispIdx];
                    out_rob_id        <= r_dest[w_dispIdx];
                    out_tja           <= r_tja[w_dispIdx];
                    out_fja           <= r_fja[w_dispIdx];
                end else if (w_load) begin
                    out_valid <= 1'b0;
                end

                if (w_issue) begin
                    r_busy[w_issueIdx] <= 1'b1;
                    r_op[w_issueIdx]   <= op_type;
                    r_vj[w_issueIdx]   <= w_newVj;
                    r_vk[w_issueIdx]   <= w_newVk;
                    r_dj[w_issueIdx]   <= w_newDj;
                    r_dk[w_issueIdx]   <= w_newDk;
                    r_qj[w_issueIdx]   <= dep_j;
                    r_qk[w_issueIdx]   <= dep_k;
                    r_dest[w_issueIdx] <= rob_id;
                    r_tja[w_issueIdx]  <= tja;
                    r_fja[w_issueIdx]  <= fja;
                    r_age[w_issueIdx]  <= '0;
                end
            end
        end
    end

endmodule
